blctrl_update_scheduler: RTL and testbench

Sequences periodic speed-update writes to up to eight BL-Ctrl ESCs (I2C addresses 0x29..0x30) over one shared byte-write I2C master. Each refresh period it sweeps the enabled motors in index order and issues one single-byte write per motor. When the global enable drops, it issues a zero-speed write to all eight motors. It sits between the speed/enable register bank and the I2C master core, and reports per-motor NACK and overrun status.

---
 rtl/blctrl_pkg.sv | 23 ++
 rtl/blctrl_refresh_timer.sv | 30 +++
 rtl/blctrl_update_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_blctrl_update_scheduler.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/blctrl_pkg.sv
// Shared types and helpers for the BL-Ctrl ESC speed-update scheduler.
package blctrl_pkg;

    localparam int         NUM_MOTORS        = 8;
    localparam logic [6:0] BASE_ADDR_DEFAULT = 7'h29;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        ISSUE,
        WAIT_DONE,
        STOP_ISSUE,
        STOP_WAIT
    } state_e;

    // Motor 0 occupies the most significant byte of the flat speed bus.
    function automatic logic [7:0] speed_of(input logic [63:0] flat, input logic [2:0] i);
        logic [63:0] sh;
        sh = flat << {i, 3'b000};
        return sh[63:56];
    endfunction

endpackage

// File: rtl/blctrl_refresh_timer.sv
// Free-running refresh period counter; tick_o is high for the last count of each period.
module blctrl_refresh_timer #(
    parameter int REFRESH_CYCLES = 50000
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int            CW   = $clog2(REFRESH_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(REFRESH_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/blctrl_update_scheduler.sv
// Sweeps enabled ESCs once per refresh period with single-byte I2C writes, and
// runs a zero-speed sweep of all motors when the global enable falls.
module blctrl_update_scheduler
    import blctrl_pkg::*;
#(
    parameter int         REFRESH_CYCLES = 50000,
    parameter int         TIMEOUT_CYCLES = 20000,
    parameter logic [6:0] BASE_ADDR      = BASE_ADDR_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        master_enable_i,
    input  logic [0:7]  motor_enable_i,
    input  logic [63:0] target_speed_flat_i,
    output logic        i2c_req_valid_o,
    input  logic        i2c_req_ready_i,
    output logic [6:0]  i2c_req_addr_o,
    output logic [7:0]  i2c_req_data_o,
    input  logic        i2c_done_i,
    input  logic        i2c_nack_i,
    output logic        sweep_busy_o,
    output logic        overrun_o,
    output logic [0:7]  nack_status_o,
    input  logic        clear_status_i
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_e        state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [6:0]    addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          tick_pend_q, tick_pend_d;
    logic          stop_pend_q, stop_pend_d;
    logic          en_q, en_prev_q;
    logic          overrun_q, overrun_d;
    logic [0:7]    nack_q, nack_d;
    logic [0:7]    nack_set;
    logic          tick, handshake, tmo_hit, txn_end, stop_req;
    logic [3:0]    idx_inc;

    blctrl_refresh_timer #(
        .REFRESH_CYCLES(REFRESH_CYCLES)
    ) u_timer (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .tick_o(tick)
    );

    assign i2c_req_valid_o = (state_q == ISSUE) || (state_q == STOP_ISSUE);
    assign i2c_req_addr_o  = addr_q;
    assign i2c_req_data_o  = data_q;
    assign sweep_busy_o    = (state_q != IDLE);
    assign overrun_o       = overrun_q;
    assign nack_status_o   = nack_q;

    assign handshake = i2c_req_valid_o && i2c_req_ready_i;
    assign tmo_hit   = (tmo_q == TW'(1));
    assign txn_end   = i2c_done_i || tmo_hit;
    assign stop_req  = en_prev_q && !en_q;
    assign idx_inc   = idx_q + 4'd1;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        data_d      = data_q;
        tmo_d       = tmo_q;
        tick_pend_d = tick_pend_q;
        stop_pend_d = stop_pend_q;
        nack_set    = '0;

        case (state_q)
            IDLE: begin
                if (stop_pend_q) begin
                    state_d = STOP_ISSUE;
                    idx_d   = '0;
                    addr_d  = BASE_ADDR;
                    data_d  = 8'h00;
                end else if (tick_pend_q && master_enable_i) begin
                    state_d     = SELECT;
                    idx_d       = '0;
                    tick_pend_d = 1'b0;
                end
            end
            SELECT: begin
                if (stop_pend_q) begin
                    state_d = STOP_ISSUE;
                    idx_d   = '0;
                    addr_d  = BASE_ADDR;
                    data_d  = 8'h00;
                end else if (idx_q[3]) begin
                    state_d = IDLE;
                end else if (motor_enable_i[idx_q[2:0]]) begin
                    state_d = ISSUE;
                    addr_d  = BASE_ADDR + {4'b0000, idx_q[2:0]};
                    data_d  = speed_of(target_speed_flat_i, idx_q[2:0]);
                end else begin
                    idx_d = idx_inc;
                end
            end
            ISSUE: begin
                if (handshake) begin
                    state_d = WAIT_DONE;
                    tmo_d   = TW'(TIMEOUT_CYCLES);
                end else if (stop_pend_q) begin
                    state_d = STOP_ISSUE;
                    idx_d   = '0;
                    addr_d  = BASE_ADDR;
                    data_d  = 8'h00;
                end
            end
            WAIT_DONE: begin
                if (tmo_q != '0) tmo_d = tmo_q - TW'(1);
                if (txn_end) begin
                    nack_set[idx_q[2:0]] = i2c_done_i ? i2c_nack_i : 1'b1;
                    if (stop_pend_q) begin
                        state_d = STOP_ISSUE;
                        idx_d   = '0;
                        addr_d  = BASE_ADDR;
                        data_d  = 8'h00;
                    end else begin
                        state_d = SELECT;
                        idx_d   = idx_inc;
                    end
                end
            end
            STOP_ISSUE: begin
                if (handshake) begin
                    state_d = STOP_WAIT;
                    tmo_d   = TW'(TIMEOUT_CYCLES);
                end
            end
            STOP_WAIT: begin
                if (tmo_q != '0) tmo_d = tmo_q - TW'(1);
                if (txn_end) begin
                    nack_set[idx_q[2:0]] = i2c_done_i ? i2c_nack_i : 1'b1;
                    if (idx_q[2:0] == 3'd7) begin
                        state_d     = IDLE;
                        stop_pend_d = 1'b0;
                        tick_pend_d = 1'b0;
                    end else begin
                        state_d = STOP_ISSUE;
                        idx_d   = idx_inc;
                        addr_d  = BASE_ADDR + {4'b0000, idx_inc[2:0]};
                        data_d  = 8'h00;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // New events win over the end-of-sweep and SELECT-entry clears.
        if (tick)     tick_pend_d = 1'b1;
        if (stop_req) stop_pend_d = 1'b1;

        nack_d    = (clear_status_i ? '0 : nack_q) | nack_set;
        overrun_d = (clear_status_i ? 1'b0 : overrun_q) | (tick && (state_q != IDLE));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            tmo_q       <= '0;
            tick_pend_q <= 1'b0;
            stop_pend_q <= 1'b0;
            en_q        <= 1'b0;
            en_prev_q   <= 1'b0;
            overrun_q   <= 1'b0;
            nack_q      <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            tmo_q       <= tmo_d;
            tick_pend_q <= tick_pend_d;
            stop_pend_q <= stop_pend_d;
            en_q        <= master_enable_i;
            en_prev_q   <= en_q;
            overrun_q   <= overrun_d;
            nack_q      <= nack_d;
        end
    end

endmodule

// File: tb/tb_blctrl_update_scheduler.sv
// Scoreboard bench for blctrl_update_scheduler with a simple I2C master model.
module tb_blctrl_update_scheduler;

    localparam int REFRESH = 1000;
    localparam int TIMEOUT = 250;

    logic        clk;
    logic        rst;
    logic        master_enable;
    logic [0:7]  motor_enable;
    logic [63:0] target_speed_flat;
    logic        i2c_req_valid;
    logic        i2c_req_ready;
    logic [6:0]  i2c_req_addr;
    logic [7:0]  i2c_req_data;
    logic        i2c_done;
    logic        i2c_nack;
    logic        sweep_busy;
    logic        overrun;
    logic [0:7]  nack_status;
    logic        clear_status;

    blctrl_update_scheduler #(
        .REFRESH_CYCLES(REFRESH),
        .TIMEOUT_CYCLES(TIMEOUT),
        .BASE_ADDR     (7'h29)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .master_enable_i    (master_enable),
        .motor_enable_i     (motor_enable),
        .target_speed_flat_i(target_speed_flat),
        .i2c_req_valid_o    (i2c_req_valid),
        .i2c_req_ready_i    (i2c_req_ready),
        .i2c_req_addr_o     (i2c_req_addr),
        .i2c_req_data_o     (i2c_req_data),
        .i2c_done_i         (i2c_done),
        .i2c_nack_i         (i2c_nack),
        .sweep_busy_o       (sweep_busy),
        .overrun_o          (overrun),
        .nack_status_o      (nack_status),
        .clear_status_i     (clear_status)
    );

    typedef struct {
        int addr;
        int data;
        int cyc;
    } exp_t;

    exp_t       exp_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         c0      = 0;
    int         done_delay;
    logic [6:0] nack_addr;
    logic [6:0] drop_addr;
    logic [6:0] m_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc - c0);
        end
    endtask

    task automatic wait_rel(input int t);
        while (cyc < c0 + t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input int addr, input int data, input int rel);
        exp_t e;
        e.addr = addr;
        e.data = data;
        e.cyc  = c0 + rel;
        exp_q.push_back(e);
    endtask

    // Monitor: every accepted request is matched against the next expected write.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && i2c_req_valid && i2c_req_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h (cycle %0d), none expected",
                             i2c_req_addr, i2c_req_data, cyc - c0);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", 32'(i2c_req_addr), 32'(e.addr));
                    check("write_data", 32'(i2c_req_data), 32'(e.data));
                    check("write_cycle", 32'(cyc - c0), 32'(e.cyc - c0));
                end
            end
        end
    end

    // I2C master model: done pulse done_delay cycles after the handshake cycle.
    initial begin
        i2c_done = 1'b0;
        i2c_nack = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && i2c_req_valid && i2c_req_ready) begin
                m_addr = i2c_req_addr;
                if (m_addr != drop_addr) begin
                    repeat (done_delay) @(posedge clk);
                    #1;
                    i2c_done = 1'b1;
                    i2c_nack = (m_addr == nack_addr);
                    @(posedge clk);
                    #1;
                    i2c_done = 1'b0;
                    i2c_nack = 1'b0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst               = 1'b1;
        master_enable     = 1'b1;
        motor_enable      = 8'hFF;
        target_speed_flat = 64'h10203040_50607080;
        i2c_req_ready     = 1'b1;
        clear_status      = 1'b0;
        done_delay        = 50;
        nack_addr         = 7'h7F;
        drop_addr         = 7'h7F;

        repeat (3) @(negedge clk);
        check("rst_valid",   32'(i2c_req_valid), 32'd0);
        check("rst_addr",    32'(i2c_req_addr),  32'd0);
        check("rst_data",    32'(i2c_req_data),  32'd0);
        check("rst_busy",    32'(sweep_busy),    32'd0);
        check("rst_overrun", 32'(overrun),       32'd0);
        check("rst_nack",    32'(nack_status),   32'd0);

        @(negedge clk);
        rst = 1'b0;
        c0  = cyc;

        // Two full sweeps of all motors; each write 52 cycles after the previous one.
        for (int s = 1; s <= 2; s++)
            for (int i = 0; i < 8; i++)
                push_exp(8'h29 + i, 8'h10 * (i + 1), s * REFRESH + 2 + 52 * i);

        wait_rel(1000);
        check("busy_before_sweep", 32'(sweep_busy), 32'd0);
        wait_rel(1001);
        check("busy_select_entry", 32'(sweep_busy), 32'd1);

        wait_rel(2500);
        check("overrun_normal", 32'(overrun),     32'd0);
        check("busy_idle",      32'(sweep_busy),  32'd0);
        check("nack_clean",     32'(nack_status), 32'd0);

        // Sparse enables: motors 1 and 7 only, motor 1 NACKs.
        motor_enable = 8'b0100_0001;
        nack_addr    = 7'h2A;
        push_exp(8'h2A, 8'h20, 3003);
        push_exp(8'h30, 8'h80, 3060);
        wait_rel(3053);
        check("nack_before_done", 32'(nack_status), 32'h00);
        wait_rel(3054);
        check("nack_motor1", 32'(nack_status), 32'h40);
        wait_rel(3111);
        check("busy_last_select", 32'(sweep_busy), 32'd1);
        wait_rel(3112);
        check("busy_drop", 32'(sweep_busy), 32'd0);

        wait_rel(3300);
        clear_status = 1'b1;
        wait_rel(3301);
        clear_status = 1'b0;
        check("nack_cleared", 32'(nack_status), 32'h00);

        // Clear coincides with a new NACK: the set wins.
        push_exp(8'h2A, 8'h20, 4003);
        push_exp(8'h30, 8'h80, 4060);
        wait_rel(4053);
        clear_status = 1'b1;
        wait_rel(4054);
        clear_status = 1'b0;
        check("nack_set_beats_clear", 32'(nack_status), 32'h40);

        wait_rel(4200);
        clear_status = 1'b1;
        wait_rel(4201);
        clear_status = 1'b0;
        check("nack_cleared2", 32'(nack_status), 32'h00);
        motor_enable = 8'hFF;
        nack_addr    = 7'h7F;
        drop_addr    = 7'h2C;

        // Motor 3 never completes: timeout after TIMEOUT cycles, motor 4 two cycles later.
        for (int i = 0; i < 4; i++) push_exp(8'h29 + i, 8'h10 * (i + 1), 5002 + 52 * i);
        for (int i = 4; i < 8; i++) push_exp(8'h29 + i, 8'h10 * (i + 1), 5410 + 52 * (i - 4));
        wait_rel(5408);
        check("nack_before_timeout", 32'(nack_status), 32'h00);
        wait_rel(5409);
        check("nack_timeout_motor3", 32'(nack_status), 32'h10);

        wait_rel(5700);
        check("overrun_still_clear", 32'(overrun), 32'd0);
        drop_addr  = 7'h7F;
        done_delay = 200;

        // Long sweep overruns the next tick; the pending sweep follows right after.
        for (int i = 0; i < 8; i++) push_exp(8'h29 + i, 8'h10 * (i + 1), 6002 + 202 * i);
        for (int i = 0; i < 3; i++) push_exp(8'h29 + i, 8'h10 * (i + 1), 7620 + 52 * i);
        // Stop sweep after motor 2 completes.
        for (int k = 0; k < 8; k++) push_exp(8'h29 + k, 0, 7775 + 51 * k);

        wait_rel(6999);
        check("overrun_before_tick", 32'(overrun), 32'd0);
        wait_rel(7000);
        check("overrun_set", 32'(overrun), 32'd1);
        wait_rel(7617);
        done_delay = 50;
        check("busy_after_last_done", 32'(sweep_busy), 32'd1);
        wait_rel(7618);
        check("busy_gap", 32'(sweep_busy), 32'd0);
        wait_rel(7619);
        check("busy_next_sweep", 32'(sweep_busy), 32'd1);

        wait_rel(7730);
        master_enable = 1'b0;
        wait_rel(8182);
        check("busy_stop_last", 32'(sweep_busy), 32'd1);
        wait_rel(8183);
        check("busy_stop_end", 32'(sweep_busy), 32'd0);

        wait_rel(9500);
        check("no_writes_while_disabled", 32'(exp_q.size()), 32'd0);
        check("overrun_sticky", 32'(overrun), 32'd1);

        // Empty enable mask: sweep walks all indices and issues nothing.
        motor_enable  = 8'h00;
        master_enable = 1'b1;
        wait_rel(9509);
        check("busy_empty_sweep", 32'(sweep_busy), 32'd1);
        wait_rel(9510);
        check("busy_empty_done", 32'(sweep_busy), 32'd0);

        // Stop sweep from idle: first zero write three cycles after the fall.
        wait_rel(9600);
        master_enable = 1'b0;
        for (int k = 0; k < 8; k++) push_exp(8'h29 + k, 0, 9603 + 51 * k);

        for (int k = 0; k < 3000 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        check("all_writes_seen", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
